// File: rtl/rgb_fade_sequencer.sv
// RGB fade sequencer: ramps three PWM width registers toward commanded targets,
// one step per (hold+1) PWM frames, updating widths only at frame boundaries.
module rgb_fade_sequencer #(
  parameter int W  = 32,
  parameter int HW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [W-1:0]  period,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [W-1:0]  cmd_r,
  input  logic [W-1:0]  cmd_g,
  input  logic [W-1:0]  cmd_b,
  input  logic [W-1:0]  cmd_step,
  input  logic [HW-1:0] cmd_hold,
  input  logic          abort,
  output logic [W-1:0]  width_r,
  output logic [W-1:0]  width_g,
  output logic [W-1:0]  width_b,
  output logic          busy,
  output logic          done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RAMP,
    S_DONE
  } state_t;

  state_t        state;
  logic [W-1:0]  fcnt;
  logic          tick;
  logic [HW-1:0] hcnt;
  logic [HW-1:0] hold;
  logic [W-1:0]  step;
  logic [W-1:0]  tgt_r, tgt_g, tgt_b;
  logic          at_target;

  // >= rather than == so a period lowered below the running count still ends the frame.
  assign tick      = (fcnt >= period);
  assign at_target = (width_r == tgt_r) && (width_g == tgt_g) && (width_b == tgt_b);

  // One step toward target; W+1-bit arithmetic catches carry/borrow so the result
  // saturates at the target instead of wrapping.
  function automatic logic [W-1:0] step_ch(input logic [W-1:0] w,
                                           input logic [W-1:0] t,
                                           input logic [W-1:0] s);
    logic [W:0] sum;
    logic [W:0] diff;
    sum     = {1'b0, w} + {1'b0, s};
    diff    = {1'b0, w} - {1'b0, s};
    step_ch = w;
    if (s == '0)
      step_ch = t;
    else if (w < t)
      step_ch = (sum > {1'b0, t}) ? t : sum[W-1:0];
    else if (w > t)
      step_ch = (diff[W] || (diff[W-1:0] < t)) ? t : diff[W-1:0];
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fcnt <= '0;
    end else if (tick) begin
      fcnt <= '0;
    end else begin
      fcnt <= fcnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      width_r   <= '0;
      width_g   <= '0;
      width_b   <= '0;
      tgt_r     <= '0;
      tgt_g     <= '0;
      tgt_b     <= '0;
      step      <= '0;
      hold      <= '0;
      hcnt      <= '0;
      cmd_ready <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            tgt_r     <= cmd_r;
            tgt_g     <= cmd_g;
            tgt_b     <= cmd_b;
            step      <= cmd_step;
            hold      <= cmd_hold;
            hcnt      <= '0;
            state     <= S_RAMP;
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
          end
        end

        S_RAMP: begin
          if (abort) begin
            state     <= S_IDLE;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
          end else if (at_target) begin
            state <= S_DONE;
            done  <= 1'b1;
          end else if (tick) begin
            if (hcnt == hold) begin
              width_r <= step_ch(width_r, tgt_r, step);
              width_g <= step_ch(width_g, tgt_g, step);
              width_b <= step_ch(width_b, tgt_b, step);
              hcnt    <= '0;
            end else begin
              hcnt <= hcnt + 1'b1;
            end
          end
        end

        S_DONE: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end

        default: begin
          state     <= S_IDLE;
          done      <= 1'b0;
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
